// File: rtl/decoder_seq_n.sv
`default_nettype none
// ============================================================================
// Module      : decoder_seq_n
// Description : Registered SEL_W-to-2**SEL_W one-hot decoder with a
//               valid/ready input handshake and three output modes:
//               LEVEL (hold), PULSE (one-cycle strobe) and SCAN (timed
//               one-hot walk over every line).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1        rising-edge clock
//   rst           in   1        synchronous reset, active-high
//   en_i          in   1        global enable; 0 clears outputs next edge
//   mode_i        in   2        00 LEVEL, 01 PULSE, 10 SCAN, 11 reserved
//   din_i         in   SEL_W    select index
//   din_valid_i   in   1        select request
//   din_ready_o   out  1        request can be accepted this cycle
//   dwell_i       in   DWELL_W  SCAN cycles per position minus 1
//   dout_o        out  OUT_W    one-hot output lines
//   dout_valid_o  out  1        dout_o is non-zero
//   busy_o        out  1        strobe or scan in progress
// ============================================================================
module decoder_seq_n #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [1:0]         mode_i,
  input  logic [SEL_W-1:0]   din_i,
  input  logic               din_valid_i,
  output logic               din_ready_o,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [2**SEL_W-1:0] dout_o,
  output logic               dout_valid_o,
  output logic               busy_o
);

  localparam int OUT_W = 2**SEL_W;

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;

  localparam logic [OUT_W-1:0] ONE      = OUT_W'(1);
  localparam logic [SEL_W:0]   LAST_POS = (SEL_W+1)'(OUT_W-1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_STROBE = 2'd2,
    ST_SCAN   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   dout_q, dout_d;
  logic               dout_valid_q;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  // One bit wider than idx so it can distinguish "visited all OUT_W lines".
  logic [SEL_W:0]     pos_q, pos_d;

  logic accept;

  assign din_ready_o  = en_i & ((state_q == ST_IDLE) | (state_q == ST_HOLD));
  assign accept       = din_valid_i & din_ready_o;
  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign busy_o       = (state_q == ST_STROBE) | (state_q == ST_SCAN);

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    dwell_d = dwell_q;
    pos_d   = pos_q;

    if (!en_i) begin
      state_d = ST_IDLE;
      dout_d  = '0;
      idx_d   = '0;
      dcnt_d  = '0;
      dwell_d = '0;
      pos_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            case (mode_i)
              MODE_LEVEL: begin
                dout_d  = ONE << din_i;
                state_d = ST_HOLD;
              end
              MODE_PULSE: begin
                dout_d  = ONE << din_i;
                state_d = ST_STROBE;
              end
              MODE_SCAN: begin
                dout_d  = ONE << din_i;
                idx_d   = din_i;
                dcnt_d  = '0;
                pos_d   = '0;
                dwell_d = dwell_i;
                state_d = ST_SCAN;
              end
              default: begin
                // Reserved mode: request is consumed, nothing is driven.
                dout_d  = '0;
                state_d = ST_IDLE;
              end
            endcase
          end
        end
        ST_STROBE: begin
          dout_d  = '0;
          state_d = ST_IDLE;
        end
        ST_SCAN: begin
          if (dcnt_q == dwell_q) begin
            dcnt_d = '0;
            if (pos_q == LAST_POS) begin
              dout_d  = '0;
              idx_d   = '0;
              pos_d   = '0;
              state_d = ST_IDLE;
            end else begin
              idx_d  = idx_q + 1'b1;
              pos_d  = pos_q + 1'b1;
              dout_d = ONE << (idx_q + 1'b1);
            end
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: begin
          dout_d  = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      idx_q        <= '0;
      dcnt_q       <= '0;
      dwell_q      <= '0;
      pos_q        <= '0;
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      dout_valid_q <= |dout_d;
      idx_q        <= idx_d;
      dcnt_q       <= dcnt_d;
      dwell_q      <= dwell_d;
      pos_q        <= pos_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decoder_seq_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_seq_n
// Description : Directed self-checking bench for decoder_seq_n (SEL_W=3
//               instance plus a small SEL_W=1 instance for the wrap case).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_seq_n;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [2:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [3:0] dwell;
  logic [7:0] dout;
  logic       dout_valid;
  logic       busy;

  logic       s_en;
  logic [1:0] s_mode;
  logic [0:0] s_din;
  logic       s_din_valid;
  logic       s_din_ready;
  logic [1:0] s_dwell;
  logic [1:0] s_dout;
  logic       s_dout_valid;
  logic       s_busy;

  int checks   = 0;
  int failures = 0;

  decoder_seq_n #(.SEL_W(3), .DWELL_W(4)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en),
    .mode_i       (mode),
    .din_i        (din),
    .din_valid_i  (din_valid),
    .din_ready_o  (din_ready),
    .dwell_i      (dwell),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .busy_o       (busy)
  );

  decoder_seq_n #(.SEL_W(1), .DWELL_W(2)) u_small (
    .clk          (clk),
    .rst          (rst),
    .en_i         (s_en),
    .mode_i       (s_mode),
    .din_i        (s_din),
    .din_valid_i  (s_din_valid),
    .din_ready_o  (s_din_ready),
    .dwell_i      (s_dwell),
    .dout_o       (s_dout),
    .dout_valid_o (s_dout_valid),
    .busy_o       (s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the full output set of the main instance in one call.
  task automatic check_out(input string tag, input logic [7:0] e_dout,
                           input logic e_busy, input logic e_ready);
    check({tag, ".dout"},  32'(dout),       32'(e_dout));
    check({tag, ".valid"}, 32'(dout_valid), 32'(e_dout != 8'h00));
    check({tag, ".busy"},  32'(busy),       32'(e_busy));
    check({tag, ".ready"}, 32'(din_ready),  32'(e_ready));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; din = 3'd0; din_valid = 1'b0; dwell = 4'd0;
    s_en = 1'b0; s_mode = 2'b00; s_din = 1'b0; s_din_valid = 1'b0; s_dwell = 2'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_out("reset", 8'h00, 1'b0, 1'b0);
    en = 1'b1;
    #1;
    check("ready_en", 32'(din_ready), 32'd1);

    // LEVEL: hold, then replace without a zero gap
    mode = 2'b00; din = 3'd5; din_valid = 1'b1;
    tick();
    check_out("level5", 8'b0010_0000, 1'b0, 1'b1);
    din = 3'd2;
    tick();
    check_out("level2", 8'b0000_0100, 1'b0, 1'b1);
    din_valid = 1'b0; din = 3'd6;
    tick();
    check_out("level_hold", 8'b0000_0100, 1'b0, 1'b1);

    // PULSE from HOLD, back-to-back requests give one pulse per two cycles
    mode = 2'b01; din = 3'd7; din_valid = 1'b1;
    tick();
    check_out("pulse1", 8'h80, 1'b1, 1'b0);
    tick();
    check_out("pulse_gap", 8'h00, 1'b0, 1'b1);
    tick();
    check_out("pulse2", 8'h80, 1'b1, 1'b0);
    din_valid = 1'b0;
    tick();
    check_out("pulse_end", 8'h00, 1'b0, 1'b1);

    // SCAN din=6 dwell=1: 6,7,0,...,5 two cycles each; inputs changed mid-scan
    mode = 2'b10; din = 3'd6; dwell = 4'd1; din_valid = 1'b1;
    tick();
    check_out("scan_c0", 8'h40, 1'b1, 1'b0);
    mode = 2'b00; din = 3'd0; dwell = 4'd9;
    for (int c = 1; c < 16; c++) begin
      if (c == 15) din_valid = 1'b0;
      tick();
      check_out($sformatf("scan_c%0d", c), 8'(32'd1 << ((6 + c / 2) % 8)), 1'b1, 1'b0);
    end
    tick();
    check_out("scan_end", 8'h00, 1'b0, 1'b1);

    // SCAN with dwell=0: one cycle per line, 0..7
    mode = 2'b10; din = 3'd0; dwell = 4'd0; din_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      din_valid = 1'b0;
      check_out($sformatf("scan0_c%0d", c), 8'(32'd1 << c), 1'b1, 1'b0);
    end
    tick();
    check_out("scan0_end", 8'h00, 1'b0, 1'b1);

    // en drop mid-SCAN
    mode = 2'b10; din = 3'd0; dwell = 4'd3; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check_out("en_scan", 8'h01, 1'b1, 1'b0);
    tick(); tick();
    en = 1'b0;
    tick();
    check_out("en_drop", 8'h00, 1'b0, 1'b0);
    en = 1'b1;
    tick(); tick();
    check_out("en_back", 8'h00, 1'b0, 1'b1);

    // Reset during HOLD, STROBE and SCAN
    mode = 2'b00; din = 3'd3; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check_out("rst_hold_pre", 8'h08, 1'b0, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_out("rst_hold", 8'h00, 1'b0, 1'b1);
    mode = 2'b01; din = 3'd1; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check_out("rst_strobe_pre", 8'h02, 1'b1, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    check_out("rst_strobe", 8'h00, 1'b0, 1'b1);
    mode = 2'b10; din = 3'd4; dwell = 4'd2; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    check_out("rst_scan_pre", 8'h10, 1'b1, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    check_out("rst_scan", 8'h00, 1'b0, 1'b1);

    // Reserved mode from IDLE and from HOLD
    mode = 2'b11; din = 3'd2; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check_out("mode11_idle", 8'h00, 1'b0, 1'b1);
    mode = 2'b00; din = 3'd4; din_valid = 1'b1;
    tick();
    check_out("mode11_hold_pre", 8'h10, 1'b0, 1'b1);
    mode = 2'b11;
    tick();
    din_valid = 1'b0;
    check_out("mode11_hold", 8'h00, 1'b0, 1'b1);

    // SEL_W=1 instance: SCAN din=1 dwell=2 -> line1 x3, line0 x3, then 0
    s_en = 1'b1; s_mode = 2'b10; s_din = 1'b1; s_dwell = 2'd2; s_din_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      s_din_valid = 1'b0;
      check($sformatf("small_c%0d", c), 32'(s_dout), (c < 3) ? 32'h2 : 32'h1);
      check($sformatf("small_busy%0d", c), 32'(s_busy), 32'd1);
    end
    tick();
    check("small_end", 32'(s_dout), 32'h0);
    check("small_valid", 32'(s_dout_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
